// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter between ALU results and buffered load responses
// Load responses wait in an in-order FIFO; the ALU wins ties unless the FIFO is full or its head has starved.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] pending,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        fifo_empty, fifo_full;
  logic        grant_fifo, grant_alu, push;

  always_comb begin
    head_rd    = fifo_rd_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    mem_ready  = (count_q < DEPTH_C);
    push       = mem_valid && mem_ready;

    grant_fifo = !fifo_empty && (!alu_valid || fifo_full || (starve_q >= LIMIT_C));
    grant_alu  = alu_valid && !grant_fifo;
    alu_stall  = alu_valid && grant_fifo;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (grant_fifo) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({push, grant_fifo})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Counts only cycles where a buffered head exists and loses to the ALU.
    starve_d = starve_q;
    if (fifo_empty || grant_fifo) starve_d = '0;
    else if (starve_q < LIMIT_C)  starve_d = starve_q + 1'b1;

    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (grant_fifo && head_rd != 5'd0) begin
      regwrite_d = 1'b1;
      rd_d       = head_rd;
      wdata_d    = head_data;
    end else if (grant_alu && alu_rd != 5'd0) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      wdata_d    = alu_data;
    end

    // Clear first so a same-cycle issue to the same register keeps it pending.
    pending_d = pending_q;
    if (grant_fifo) pending_d[head_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign pending    = pending_q;
  assign RegWrite   = regwrite_q;
  assign rd         = rd_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] pending;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        iv;
    logic [4:0]  ird;
    logic        stall;
    logic        ready;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                              logic mv, logic [4:0] mrd, logic [31:0] mdat,
                              logic iv, logic [4:0] ird,
                              logic stall, logic ready,
                              logic we, logic [4:0] erd, logic [31:0] wd, logic [31:0] pend);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.iv = iv; v.ird = ird;
    v.stall = stall; v.ready = ready;
    v.we = we; v.rd = erd; v.wd = wd; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
    issue_valid = v.iv; issue_rd = v.ird;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  initial begin
    // av ard adat            mv mrd mdat        iv ird  stall ready  we rd wd            pend
    vecs.push_back(mk(1, 5,  32'hAA,      0, 0,  0,          0, 0,  0, 1,  1, 5,  32'hAA,    32'h0));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 5,  32'hAA,    32'h0));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          1, 7,  0, 1,  0, 5,  32'hAA,    32'h80));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 5,  32'hAA,    32'h80));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 5,  32'hAA,    32'h80));
    vecs.push_back(mk(0, 0,  0,           1, 7,  32'h1234,   0, 0,  0, 1,  0, 5,  32'hAA,    32'h80));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  1, 7,  32'h1234,  32'h0));
    vecs.push_back(mk(1, 0,  32'hFFFFFFFF,0, 0,  0,          1, 0,  0, 1,  0, 7,  32'h1234,  32'h0));
    vecs.push_back(mk(0, 0,  0,           1, 9,  32'h99,     1, 9,  0, 1,  0, 7,  32'h1234,  32'h200));
    vecs.push_back(mk(1, 10, 32'hA10,     0, 0,  0,          0, 0,  0, 1,  1, 10, 32'hA10,   32'h200));
    vecs.push_back(mk(1, 11, 32'hA11,     0, 0,  0,          0, 0,  0, 1,  1, 11, 32'hA11,   32'h200));
    vecs.push_back(mk(1, 12, 32'hA12,     0, 0,  0,          0, 0,  0, 1,  1, 12, 32'hA12,   32'h200));
    vecs.push_back(mk(1, 13, 32'hA13,     0, 0,  0,          0, 0,  0, 1,  1, 13, 32'hA13,   32'h200));
    vecs.push_back(mk(1, 14, 32'hA14,     0, 0,  0,          0, 0,  1, 1,  1, 9,  32'h99,    32'h0));
    vecs.push_back(mk(1, 14, 32'hA14,     0, 0,  0,          0, 0,  0, 1,  1, 14, 32'hA14,   32'h0));
    vecs.push_back(mk(1, 15, 32'hA15,     1, 16, 32'h160,    0, 0,  0, 1,  1, 15, 32'hA15,   32'h0));
    vecs.push_back(mk(1, 17, 32'hA17,     1, 18, 32'h180,    0, 0,  0, 1,  1, 17, 32'hA17,   32'h0));
    vecs.push_back(mk(1, 19, 32'hA19,     0, 0,  0,          0, 0,  1, 0,  1, 16, 32'h160,   32'h0));
    vecs.push_back(mk(1, 19, 32'hA19,     0, 0,  0,          0, 0,  0, 1,  1, 19, 32'hA19,   32'h0));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  1, 18, 32'h180,   32'h0));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 18, 32'h180,   32'h0));
    vecs.push_back(mk(0, 0,  0,           1, 3,  32'h33,     1, 3,  0, 1,  0, 18, 32'h180,   32'h8));
    vecs.push_back(mk(0, 0,  0,           1, 4,  32'h44,     1, 3,  0, 1,  1, 3,  32'h33,    32'h8));
    vecs.push_back(mk(0, 0,  0,           1, 0,  32'hDEAD,   0, 0,  0, 1,  1, 4,  32'h44,    32'h8));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 4,  32'h44,    32'h8));
    vecs.push_back(mk(0, 0,  0,           0, 0,  0,          0, 0,  0, 1,  0, 4,  32'h44,    32'h8));

    #2 rst_n = 1'b0;
    #1;
    check("reset_regwrite", 32'(RegWrite), 32'h0);
    check("reset_rd", 32'(rd), 32'h0);
    check("reset_wdata", write_data, 32'h0);
    check("reset_pending", pending, 32'h0);
    check("reset_mem_ready", 32'(mem_ready), 32'h1);
    check("reset_alu_stall", 32'(alu_stall), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #3;
      check($sformatf("v%0d_alu_stall", i), 32'(alu_stall), 32'(vecs[i].stall));
      check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(vecs[i].we));
      check($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_wdata", i), write_data, vecs[i].wd);
      check($sformatf("v%0d_pending", i), pending, vecs[i].pend);
    end

    // Fill the FIFO behind winning ALU traffic, then reset mid-cycle.
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h21;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(posedge clk); #1;
    alu_rd = 5'd22; alu_data = 32'h22;
    mem_rd = 5'd23; mem_data = 32'h23;
    issue_valid = 1'b0; issue_rd = '0;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check("prereset_mem_ready", 32'(mem_ready), 32'h0);
    check("prereset_pending", pending, 32'h88);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_regwrite", 32'(RegWrite), 32'h0);
    check("midreset_rd", 32'(rd), 32'h0);
    check("midreset_wdata", write_data, 32'h0);
    check("midreset_pending", pending, 32'h0);
    check("midreset_mem_ready", 32'(mem_ready), 32'h1);
    check("midreset_alu_stall", 32'(alu_stall), 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("postreset%0d_regwrite", c), 32'(RegWrite), 32'h0);
      check($sformatf("postreset%0d_mem_ready", c), 32'(mem_ready), 32'h1);
      check($sformatf("postreset%0d_pending", c), pending, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
